// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter and its result FIFOs.
package cdb_arbiter_pkg;

    localparam int DAT_W      = 32;
    localparam int ROB_BIT    = 4;
    localparam int CDB_FIFO_D = 4;

    // Identifies which producer owns a broadcast slot.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_result_fifo.sv
// Ring-buffer result FIFO with occupancy count, head output and synchronous clear.
module cdb_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB between the ALU and LSB result streams.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DAT_W   = cdb_arbiter_pkg::DAT_W,
    parameter int ROB_BIT = cdb_arbiter_pkg::ROB_BIT,
    parameter int FIFO_D  = cdb_arbiter_pkg::CDB_FIFO_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               br_flag,
    input  logic               alu_en_i,
    input  logic [ROB_BIT-1:0] alu_q_i,
    input  logic [DAT_W-1:0]   alu_v_i,
    output logic               alu_rdy_o,
    input  logic               lsb_en_i,
    input  logic [ROB_BIT-1:0] lsb_q_i,
    input  logic [DAT_W-1:0]   lsb_v_i,
    output logic               lsb_rdy_o,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o
);

    localparam int EW = ROB_BIT + DAT_W;
    localparam int CW = $clog2(FIFO_D) + 1;

    logic [CW-1:0]      alu_cnt, lsb_cnt;
    logic               alu_empty, lsb_empty;
    logic [EW-1:0]      alu_head, lsb_head, alu_entry, lsb_entry;
    logic               alu_acc, lsb_acc, alu_cand, lsb_cand;
    logic               grant_alu, grant_lsb;
    logic               alu_push, alu_pop, lsb_push, lsb_pop;

    logic               cdb_en_q, cdb_en_d;
    logic [ROB_BIT-1:0] cdb_q_q, cdb_q_d;
    logic [DAT_W-1:0]   cdb_v_q, cdb_v_d;
    src_e               last_grant_q, last_grant_d;

    // Readiness looks only at the pre-edge count, so a full FIFO popping this cycle still refuses.
    assign alu_rdy_o = en && !br_flag && (alu_cnt < CW'(FIFO_D));
    assign lsb_rdy_o = en && !br_flag && (lsb_cnt < CW'(FIFO_D));
    assign alu_acc   = alu_en_i && alu_rdy_o;
    assign lsb_acc   = lsb_en_i && lsb_rdy_o;

    assign alu_cand  = en && (!alu_empty || alu_acc);
    assign lsb_cand  = en && (!lsb_empty || lsb_acc);
    assign alu_entry = alu_empty ? {alu_q_i, alu_v_i} : alu_head;
    assign lsb_entry = lsb_empty ? {lsb_q_i, lsb_v_i} : lsb_head;

    assign grant_alu = alu_cand && (!lsb_cand || (last_grant_q == SRC_LSB));
    assign grant_lsb = lsb_cand && !grant_alu;

    assign alu_pop  = grant_alu && !alu_empty && !br_flag;
    assign lsb_pop  = grant_lsb && !lsb_empty && !br_flag;
    assign alu_push = alu_acc && !(alu_empty && grant_alu);
    assign lsb_push = lsb_acc && !(lsb_empty && grant_lsb);

    cdb_result_fifo #(.DEPTH(FIFO_D), .WIDTH(EW)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (br_flag),
        .push_i  (alu_push),
        .pop_i   (alu_pop),
        .din_i   ({alu_q_i, alu_v_i}),
        .head_o  (alu_head),
        .count_o (alu_cnt),
        .empty_o (alu_empty)
    );

    cdb_result_fifo #(.DEPTH(FIFO_D), .WIDTH(EW)) u_lsb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (br_flag),
        .push_i  (lsb_push),
        .pop_i   (lsb_pop),
        .din_i   ({lsb_q_i, lsb_v_i}),
        .head_o  (lsb_head),
        .count_o (lsb_cnt),
        .empty_o (lsb_empty)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cdb_en_d     = 1'b0;
        cdb_q_d      = cdb_q_q;
        cdb_v_d      = cdb_v_q;
        last_grant_d = last_grant_q;
        if (br_flag) begin
            last_grant_d = SRC_LSB;
        end else if (grant_alu) begin
            cdb_en_d           = 1'b1;
            {cdb_q_d, cdb_v_d} = alu_entry;
            last_grant_d       = SRC_ALU;
        end else if (grant_lsb) begin
            cdb_en_d           = 1'b1;
            {cdb_q_d, cdb_v_d} = lsb_entry;
            last_grant_d       = SRC_LSB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_en_q     <= 1'b0;
            cdb_q_q      <= '0;
            cdb_v_q      <= '0;
            last_grant_q <= SRC_LSB;
        end else begin
            cdb_en_q     <= cdb_en_d;
            cdb_q_q      <= cdb_q_d;
            cdb_v_q      <= cdb_v_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_en_o = cdb_en_q;
    assign cdb_q_o  = cdb_q_q;
    assign cdb_v_o  = cdb_v_q;

endmodule
